// File: rtl/alu_op_ctrl.sv
// Sequencing controller for the 32-bit combinational ALU: accepts one request,
// holds the ALU inputs for the per-opcode latency, then returns the captured result.
`timescale 1ns/1ps
module alu_op_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_opcode,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             req_cin,
    output logic             alu_en,
    output logic [3:0]       alu_opcode,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic             alu_cin,
    output logic             alu_bin,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_sign,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_parity,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int HOLD_W  = $clog2(LAT_MAX + 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_DIV = 4'd10;
    localparam logic [3:0] OP_ILL = 4'd15;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_load;
    logic              accept;
    logic              accept_legal;
    logic              accept_ill;
    logic              finish;
    logic              rsp_fire;

    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign rsp_valid    = (state == DONE);
    assign accept       = req_valid & req_ready;
    assign accept_ill   = accept & (req_opcode == OP_ILL);
    assign accept_legal = accept & (req_opcode != OP_ILL);
    assign finish       = (state == EXEC) && (hold_q == HOLD_W'(1));
    assign rsp_fire     = rsp_valid & rsp_ready;

    always_comb begin
        if (req_opcode == OP_MUL)      hold_load = HOLD_W'(MUL_LAT);
        else if (req_opcode == OP_DIV) hold_load = HOLD_W'(DIV_LAT);
        else                           hold_load = HOLD_W'(1);
    end

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = (req_opcode == OP_ILL) ? DONE : EXEC;
            EXEC:    if (finish)    state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The ALU-side registers double as the operand registers; they are only loaded on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_en     <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            alu_bin    <= 1'b0;
            hold_q     <= '0;
        end else if (accept_legal) begin
            alu_en     <= 1'b1;
            alu_opcode <= req_opcode;
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_cin    <= (req_opcode == OP_ADD) & req_cin;
            alu_bin    <= (req_opcode == OP_SUB) & req_cin;
            hold_q     <= hold_load;
        end else if (state == EXEC) begin
            hold_q <= hold_q - HOLD_W'(1);
            if (finish) begin
                alu_en     <= 1'b0;
                alu_opcode <= '0;
                alu_a      <= '0;
                alu_b      <= '0;
                alu_cin    <= 1'b0;
                alu_bin    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else if (accept_ill) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b1;
        end else if (finish) begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_zero, alu_sign, alu_carry, alu_overflow, alu_parity};
            rsp_err    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            op_count <= '0;
        else if (rsp_fire && (op_count != '1)) op_count <= op_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Scoreboard bench for alu_op_ctrl: a behavioural ALU sits on the alu_* port and a
// spec-level reference model predicts every response, its latency and its hold time.
`timescale 1ns/1ps
module tb_alu_op_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready;
    logic [3:0]       req_opcode;
    logic [31:0]      req_a, req_b;
    logic             req_cin;
    logic             alu_en;
    logic [3:0]       alu_opcode;
    logic [31:0]      alu_a, alu_b;
    logic             alu_cin, alu_bin;
    logic [31:0]      alu_result;
    logic             alu_zero, alu_sign, alu_carry, alu_overflow, alu_parity;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_result;
    logic [4:0]       rsp_flags;
    logic             rsp_err, busy;
    logic [CNT_W-1:0] op_count;

    alu_op_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_bin(alu_bin), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_parity(alu_parity),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Returns {zero, sign, carry, overflow, parity, result[31:0]}.
    function automatic logic [36:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic c);
        logic [32:0] w;
        logic [31:0] r;
        logic        cy, ov;
        w = '0; r = '0; cy = 1'b0; ov = 1'b0;
        case (op)
            4'd0: begin
                w  = {1'b0, a} + {1'b0, b} + {32'b0, c};
                r  = w[31:0];
                cy = w[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                w  = {1'b0, a} - {1'b0, b} - {32'b0, c};
                r  = w[31:0];
                cy = w[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2:  r = ~a;
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = ~(a | b);
            4'd6:  r = ~(a & b);
            4'd7:  r = a ^ b;
            4'd8:  r = ~(a ^ b);
            4'd9:  r = a * b;
            4'd10: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd11: r = {31'b0, a == b};
            4'd12: r = {31'b0, a > b};
            4'd13: r = a << b[4:0];
            4'd14: r = a >> b[4:0];
            default: r = '0;
        endcase
        return {(r == 32'd0), r[31], cy, ov, ^r, r};
    endfunction

    // Behavioural ALU: garbage when disabled, corrupted if a carry/borrow reaches an op that must not see it.
    logic [36:0] alu_mod;
    logic        alu_c, alu_bad;
    always_comb begin
        alu_c   = 1'b0;
        alu_bad = 1'b0;
        case (alu_opcode)
            4'd0:    begin alu_c = alu_cin; alu_bad = alu_bin; end
            4'd1:    begin alu_c = alu_bin; alu_bad = alu_cin; end
            default: alu_bad = alu_cin | alu_bin;
        endcase
        alu_mod = alu_fn(alu_opcode, alu_a, alu_b, alu_c);
        if (alu_bad) alu_mod = alu_mod ^ {5'b0, 32'h8000_0001};
        if (!alu_en) alu_mod = {5'b10101, 32'hDEAD_BEEF};
    end
    assign alu_result = alu_mod[31:0];
    assign {alu_zero, alu_sign, alu_carry, alu_overflow, alu_parity} = alu_mod[36:32];

    typedef struct {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        err;
        int          lat;
        int          en;
        int          t0;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t make_exp(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic cin, input int t0);
        exp_t        e;
        logic [36:0] r;
        e.t0 = t0;
        if (op == 4'd15) begin
            e.result = '0; e.flags = '0; e.err = 1'b1; e.en = 0; e.lat = 1;
        end else begin
            r        = alu_fn(op, a, b, cin);
            e.result = r[31:0];
            e.flags  = r[36:32];
            e.err    = 1'b0;
            e.en     = (op == 4'd9) ? MUL_LAT : (op == 4'd10) ? DIV_LAT : 1;
            e.lat    = 1 + e.en;
        end
        return e;
    endfunction

    // rsp_ready: forced by the main sequence or randomised each cycle.
    logic rr_force = 1'b1;
    logic rr_val   = 1'b0;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: samples one time unit after the falling edge, well away from the rising edge.
    exp_t        m_exp;
    logic        m_prev_valid;
    int          m_en_cnt;
    int          m_exp_cnt;
    logic [37:0] m_held;
    initial begin
        m_prev_valid = 1'b0; m_en_cnt = 0; m_exp_cnt = 0; m_held = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                sb.delete();
                m_prev_valid = 1'b0; m_en_cnt = 0; m_exp_cnt = 0;
                continue;
            end
            check("op_count", 64'(op_count), 64'(m_exp_cnt));
            if (alu_en) m_en_cnt++;
            if (rsp_valid) begin
                check("req_ready_in_done", 64'(req_ready), 64'd0);
                if (!m_prev_valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_rsp: got response 0x%0h, expected none (cycle %0d)",
                                 rsp_result, cyc);
                    end else begin
                        m_exp = sb.pop_front();
                        check("rsp_result",  64'(rsp_result), 64'(m_exp.result));
                        check("rsp_flags",   64'(rsp_flags),  64'(m_exp.flags));
                        check("rsp_err",     64'(rsp_err),    64'(m_exp.err));
                        check("rsp_latency", 64'(cyc - m_exp.t0), 64'(m_exp.lat));
                        check("alu_en_cycles", 64'(m_en_cnt), 64'(m_exp.en));
                    end
                    m_en_cnt = 0;
                    m_held   = {rsp_err, rsp_flags, rsp_result};
                end else begin
                    check("rsp_stable", 64'({rsp_err, rsp_flags, rsp_result}), 64'(m_held));
                end
                if (rsp_ready) m_exp_cnt = (m_exp_cnt == CNT_MAX) ? CNT_MAX : m_exp_cnt + 1;
            end
            m_prev_valid = rsp_valid;
        end
    end

    task automatic send_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic cin);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        req_cin    = cin;
        sb.push_back(make_exp(op, a, b, cin, cyc));
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_opcode = 4'($urandom);
        req_a      = $urandom;
        req_b      = $urandom;
        req_cin    = 1'($urandom);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !busy) return;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic check_reset(input string name);
        check({name, "_ctrl"},
              64'({req_ready, alu_en, alu_opcode, alu_cin, alu_bin, rsp_valid, rsp_flags,
                   rsp_err, busy, op_count}),
              64'({1'b1, 19'b0}));
        check({name, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
        check({name, "_rsp_result"}, 64'(rsp_result), 64'd0);
    endtask

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    logic [3:0]  r_op;
    logic [31:0] r_b;
    int          pick;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0; req_cin = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed ops with the consumer always ready.
        rr_force = 1'b1;
        rr_val   = 1'b1;
        send_op(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        send_op(4'd9, 32'd6, 32'd7, 1'b0);
        send_op(4'd10, 32'd100, 32'd7, 1'b0);
        send_op(4'd15, $urandom, $urandom, 1'b1);
        send_op(4'd1, 32'd10, 32'd3, 1'b1);
        send_op(4'd0, 32'h7FFF_FFFF, 32'd0, 1'b1);
        wait_idle("directed_idle");
        check("directed_op_count", 64'(op_count), 64'd6);

        // Backpressure: response held while a stray request is presented.
        rr_val = 1'b0;
        send_op(4'd1, 32'd5, 32'd3, 1'b0);
        repeat (10) begin
            @(negedge clk);
            req_valid  = 1'b1;
            req_opcode = 4'd7;
            req_a      = $urandom;
            req_b      = $urandom;
        end
        @(negedge clk);
        #1;
        check("bp_rsp_valid_held", 64'(rsp_valid), 64'd1);
        req_valid = 1'b0;
        rr_val    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (!rsp_valid) break;
        end
        check("bp_release", 64'({rsp_valid, req_ready}), 64'b01);
        check("bp_op_count", 64'(op_count), 64'd7);

        // Reset in the third EXEC cycle of a divide.
        send_op(4'd10, 32'd100, 32'd7, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_op(4'd7, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
        wait_idle("xor_idle");
        check("xor_op_count", 64'(op_count), 64'd1);

        // Random ops with random backpressure; the counter saturates along the way.
        rr_force = 1'b0;
        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 19);
            r_op = (pick <= 14) ? 4'(pick) : (pick <= 16) ? 4'd15 : (pick == 17) ? 4'd9 : 4'd10;
            r_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            send_op(r_op, $urandom, r_b, 1'($urandom));
        end
        wait_idle("random_idle");
        check("sat_op_count", 64'(op_count), 64'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
